// File: rtl/mux_trial_controller.sv
// ----------------------------------------------------------------------------
// mux_trial_controller: Monte Carlo trial sequencer for one NAND multiplexing unit.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mux_trial_controller #(
  parameter int N        = 10,
  parameter int LATENCY  = 2,
  parameter int DELTA    = 1,
  parameter int TRIALS_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_i,
  input  logic [TRIALS_W-1:0] num_trials_i,
  input  logic                x_val_i,
  input  logic                y_val_i,
  input  logic                sweep_i,
  output logic [N-1:0]        mux_x_o,
  output logic [N-1:0]        mux_y_o,
  input  logic [N-1:0]        mux_z_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [TRIALS_W-1:0] trial_count_o,
  output logic [TRIALS_W-1:0] err_count_o,
  output logic [TRIALS_W-1:0] undecided_count_o
);

  localparam int OW = $clog2(N + 1);
  localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [TRIALS_W-1:0]   ntrials_q, ntrials_d;
  logic                  x_q, x_d, y_q, y_d, sweep_q, sweep_d;
  logic [1:0]            idx_q, idx_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [TRIALS_W-1:0]   trial_q, trial_d, err_q, err_d, und_q, und_d;

  logic [OW-1:0]         ones;
  logic                  cur_x, cur_y, expected, dec_hi, dec_lo, wrong, last;

  function automatic logic [TRIALS_W-1:0] sat_inc(input logic [TRIALS_W-1:0] v);
    return (&v) ? v : v + TRIALS_W'(1);
  endfunction

  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++) ones = ones + OW'(mux_z_i[i]);
  end

  // Sweep walks (x,y) through 00,01,10,11 using the low trial-index bits.
  assign cur_x    = sweep_q ? idx_q[1] : x_q;
  assign cur_y    = sweep_q ? idx_q[0] : y_q;
  assign expected = ~(cur_x & cur_y);
  assign dec_hi   = (ones >= OW'(N - DELTA));
  assign dec_lo   = (ones <= OW'(DELTA));
  assign wrong    = (dec_hi && !expected) || (dec_lo && expected);
  assign last     = ({1'b0, trial_q} + (TRIALS_W+1)'(1)) == {1'b0, ntrials_q};

  assign busy_o            = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign done_o            = (state_q == S_DONE);
  assign mux_x_o           = busy_o ? {N{cur_x}} : '0;
  assign mux_y_o           = busy_o ? {N{cur_y}} : '0;
  assign trial_count_o     = trial_q;
  assign err_count_o       = err_q;
  assign undecided_count_o = und_q;

  always_comb begin
    state_d   = state_q;
    ntrials_d = ntrials_q;
    x_d       = x_q;
    y_d       = y_q;
    sweep_d   = sweep_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    trial_d   = trial_q;
    err_d     = err_q;
    und_d     = und_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          ntrials_d = num_trials_i;
          x_d       = x_val_i;
          y_d       = y_val_i;
          sweep_d   = sweep_i;
          idx_d     = '0;
          wait_d    = '0;
          trial_d   = '0;
          err_d     = '0;
          und_d     = '0;
          state_d   = (num_trials_i == '0) ? S_DONE : S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (wait_q == WW'(LATENCY - 1)) begin
          wait_d  = '0;
          state_d = S_SAMPLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_SAMPLE: begin
        trial_d = sat_inc(trial_q);
        if (!dec_hi && !dec_lo) und_d = sat_inc(und_q);
        else if (wrong)         err_d = sat_inc(err_q);
        idx_d   = idx_q + 2'd1;
        state_d = last ? S_DONE : S_DRIVE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ntrials_q <= '0;
      x_q       <= 1'b0;
      y_q       <= 1'b0;
      sweep_q   <= 1'b0;
      idx_q     <= '0;
      wait_q    <= '0;
      trial_q   <= '0;
      err_q     <= '0;
      und_q     <= '0;
    end else begin
      state_q   <= state_d;
      ntrials_q <= ntrials_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sweep_q   <= sweep_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      trial_q   <= trial_d;
      err_q     <= err_d;
      und_q     <= und_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_trial_controller.sv
// ----------------------------------------------------------------------------
// tb_mux_trial_controller: table-driven bench with a NAND-unit stub and scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mux_trial_controller;

  localparam int N = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start_i;
  logic [15:0]   num_trials_i;
  logic          x_val_i, y_val_i, sweep_i;
  logic [N-1:0]  mux_x_o, mux_y_o, mux_z_i;
  logic          busy_o, done_o;
  logic [15:0]   trial_count_o, err_count_o, undecided_count_o;

  logic          ideal;
  logic [N-1:0]  zforce;
  logic [N-1:0]  s1, s2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         n;
    bit         x, y, sw, ideal;
    logic [9:0] zf;
    int         glitch;
    int         et, ee, eu;
  } rec_t;

  rec_t tbl[12];
  rec_t sb[$];

  mux_trial_controller #(.N(N), .LATENCY(2), .DELTA(1), .TRIALS_W(16)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start_i           (start_i),
    .num_trials_i      (num_trials_i),
    .x_val_i           (x_val_i),
    .y_val_i           (y_val_i),
    .sweep_i           (sweep_i),
    .mux_x_o           (mux_x_o),
    .mux_y_o           (mux_y_o),
    .mux_z_i           (mux_z_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .trial_count_o     (trial_count_o),
    .err_count_o       (err_count_o),
    .undecided_count_o (undecided_count_o)
  );

  always #5 clk = ~clk;

  // Two-stage NAND unit model, or a forced constant z bundle.
  always @(posedge clk) begin
    s1 <= ~(mux_x_o & mux_y_o);
    s2 <= s1;
  end
  assign mux_z_i = ideal ? s2 : zforce;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic rec_t mk(input int n, input bit x, input bit y, input bit sw,
                              input bit id, input logic [9:0] zf, input int g,
                              input int et, input int ee, input int eu);
    rec_t r;
    r.n = n; r.x = x; r.y = y; r.sw = sw; r.ideal = id; r.zf = zf;
    r.glitch = g; r.et = et; r.ee = ee; r.eu = eu;
    return r;
  endfunction

  task automatic launch(input rec_t r);
    ideal  = r.ideal;
    zforce = r.zf;
    @(negedge clk);
    num_trials_i = 16'(r.n);
    x_val_i      = r.x;
    y_val_i      = r.y;
    sweep_i      = r.sw;
    start_i      = 1'b1;
  endtask

  task automatic run(input rec_t r);
    int   cyc;
    int   busy_cnt;
    int   t;
    bit   done_seen;
    bit   ex, ey;
    rec_t e;
    launch(r);
    sb.push_back(r);
    cyc = 0; busy_cnt = 0; done_seen = 0;
    while (!done_seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start_i = (cyc == r.glitch);
      if (cyc == r.glitch) begin
        num_trials_i = 16'd1; x_val_i = ~r.x; y_val_i = ~r.y; sweep_i = 1'b0;
      end
      if (busy_o) begin
        busy_cnt++;
        t  = (cyc - 1) / 3;
        ex = r.sw ? t[1] : r.x;
        ey = r.sw ? t[0] : r.y;
        chk("mux_x", int'(mux_x_o), ex ? 10'h3FF : 0);
        chk("mux_y", int'(mux_y_o), ey ? 10'h3FF : 0);
      end
      if (done_o) begin
        done_seen = 1;
        chk("done_cycle", cyc, 3 * r.n + 1);
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 0, 1);
        end else begin
          e = sb.pop_front();
          chk("trial_count", int'(trial_count_o), e.et);
          chk("err_count", int'(err_count_o), e.ee);
          chk("undecided_count", int'(undecided_count_o), e.eu);
        end
      end
    end
    chk("done_seen", int'(done_seen), 1);
    chk("busy_cycles", busy_cnt, 3 * r.n);
    @(negedge clk);
    start_i = 1'b0;
    chk("idle_busy", int'(busy_o), 0);
    chk("idle_done", int'(done_o), 0);
    chk("hold_trial", int'(trial_count_o), r.et);
  endtask

  initial begin
    reset_n = 1'b0; start_i = 1'b0; num_trials_i = '0;
    x_val_i = 1'b0; y_val_i = 1'b0; sweep_i = 1'b0;
    ideal = 1'b1; zforce = '0;

    tbl[0]  = mk(4, 1, 1, 0, 1, 10'h000, 0, 4, 0, 0);
    tbl[1]  = mk(3, 1, 1, 0, 0, 10'h003, 0, 3, 0, 3);
    tbl[2]  = mk(2, 1, 1, 0, 0, 10'h1FF, 0, 2, 2, 0);
    tbl[3]  = mk(8, 0, 0, 1, 1, 10'h000, 0, 8, 0, 0);
    tbl[4]  = mk(0, 1, 1, 0, 1, 10'h000, 0, 0, 0, 0);
    tbl[5]  = mk(4, 0, 1, 0, 1, 10'h000, 5, 4, 0, 0);
    tbl[6]  = mk(2, 1, 0, 0, 1, 10'h000, 7, 2, 0, 0);
    tbl[7]  = mk(4, 0, 0, 1, 0, 10'h3FF, 0, 4, 1, 0);
    tbl[8]  = mk(5, 0, 0, 1, 0, 10'h000, 0, 5, 4, 0);
    tbl[9]  = mk(2, 0, 0, 0, 0, 10'h001, 0, 2, 2, 0);
    tbl[10] = mk(3, 0, 1, 0, 0, 10'h3FE, 0, 3, 0, 0);
    tbl[11] = mk(1, 1, 1, 0, 0, 10'h0FF, 0, 1, 0, 1);

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_mux_x", int'(mux_x_o), 0);
    chk("rst_mux_y", int'(mux_y_o), 0);
    chk("rst_trial", int'(trial_count_o), 0);
    chk("rst_err", int'(err_count_o), 0);
    chk("rst_und", int'(undecided_count_o), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) run(tbl[i]);

    // Abort mid-DRIVE of the second trial; reset must act before the next edge.
    launch(tbl[0]);
    repeat (5) @(negedge clk);
    start_i = 1'b0;
    chk("pre_abort_trial", int'(trial_count_o), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_mux_x", int'(mux_x_o), 0);
    chk("abort_mux_y", int'(mux_y_o), 0);
    chk("abort_trial", int'(trial_count_o), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done_o), 0);
    end
    reset_n = 1'b1;
    run(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_trial_controller.md
Name: mux_trial_controller

Overview:
Sequences Monte Carlo trials through one N-line NAND multiplexing unit (randomizer stage plus registered erroneous-NAND stage). Drives constant-valued stimulus bundles, waits out the unit's pipeline latency, samples the output bundle, and classifies it against a threshold. Accumulates error, undecided and trial counters for the simulation harness. Sits between the testbench or host sequencer and a single multiplexing unit instance.

Parameters:
N, 10, bundle width; must match the driven multiplexing unit.
LATENCY, 2, cycles from stimulus change to valid z bundle (randomizer register + output register).
DELTA, 1, threshold: a bundle is logic 1 if ones >= N-DELTA, logic 0 if ones <= DELTA; requires 2*DELTA < N.
TRIALS_W, 16, width of the trial-count input and of all counters.

Ports:
clk  input  1  clock; all state on posedge.
reset_n  input  1  asynchronous active-low reset.
start_i  input  1  starts a run when sampled high in IDLE.
num_trials_i  input  TRIALS_W  number of trials; captured at start.
x_val_i  input  1  logical x value; captured at start; used when sweep_i=0.
y_val_i  input  1  logical y value; captured at start; used when sweep_i=0.
sweep_i  input  1  captured at start; 1 = cycle (x,y) through 00,01,10,11 per trial.
mux_x_o  output  N  x bundle to the multiplexing unit.
mux_y_o  output  N  y bundle to the multiplexing unit.
mux_z_i  input  N  z bundle from the multiplexing unit.
busy_o  output  1  high while in DRIVE or SAMPLE.
done_o  output  1  one-cycle pulse at run end.
trial_count_o  output  TRIALS_W  trials completed.
err_count_o  output  TRIALS_W  trials decided to the wrong value.
undecided_count_o  output  TRIALS_W  trials whose ones-count falls strictly between thresholds.

Behaviour:
- Reset, asynchronous: state=IDLE; all outputs and counters 0; mux_x_o=mux_y_o=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: when start_i=1, capture the inputs and clear the three counters. Trial index=0. Go to DRIVE, or to DONE if num_trials_i=0.
- DRIVE: mux_x_o={N{x}}, mux_y_o={N{y}} for the current pair. Stays exactly LATENCY cycles, counted by a wait counter, then goes to SAMPLE.
- Pair selection: sweep=0 uses the captured x_val/y_val. sweep=1 uses trial index[1:0], where x=bit1 and y=bit0.
- Stimulus is held constant through DRIVE and SAMPLE of a trial and changes only when the next trial's DRIVE begins.
- SAMPLE, one cycle:
  - ones = popcount(mux_z_i), width clog2(N+1).
  - expected = ~(x & y).
  - decided 1 if ones >= N-DELTA; decided 0 if ones <= DELTA; otherwise undecided.
  - undecided: increment undecided_count_o. Decided != expected: increment err_count_o.
  - trial_count_o always increments.
  - If trial_count+1 == num_trials, go to DONE; else go to DRIVE for the next trial.
- Each trial takes LATENCY+1 cycles. busy_o is high for num_trials*(LATENCY+1) cycles.
- DONE: done_o=1 and busy_o=0 for one cycle, then IDLE.
- Counters hold their values after done until the next accepted start.
- All counters saturate at 2^TRIALS_W-1.
- start_i is ignored outside IDLE. start_i in the DONE cycle is ignored.
- reset_n low mid-run aborts immediately; no done pulse is produced.

Test Plan:
1. Ideal stub (z = NAND, 2-cycle latency, N=10, LATENCY=2, DELTA=1); start with num_trials=4, x=1, y=1, sweep=0 -> mux_x_o=mux_y_o=10'h3FF; busy_o high 12 cycles; done_o pulse on the 13th cycle after the start edge; trial=4, err=0, undecided=0.
2. Stub forcing z=10'b0000000011, num_trials=3, x=y=1 -> 2 ones (between 1 and 9) each trial; undecided=3, err=0, trial=3.
3. Stub forcing z=10'b0111111111, num_trials=2, x=y=1 -> 9 ones decides 1, expected 0; err=2, undecided=0.
4. Ideal stub, sweep=1, num_trials=8 -> mux_x_o/mux_y_o per trial 000/000, 000/3FF, 3FF/000, 3FF/3FF, repeating; err=0, trial=8.
5. num_trials=0 -> no DRIVE cycles; done_o pulses the cycle after the start edge; counters 0. A second start asserted while busy in another run is ignored and counts are unaffected.
6. reset_n driven low mid-DRIVE between clock edges -> state IDLE, mux_x_o/mux_y_o, counters and busy_o are 0 immediately, before the next edge; no done_o; after release a new start runs normally.
